// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
//   Shared constants for the arrow-button front end: button bit positions,
//   channel count, default debounce length and the press lockout length.
//   No ports; imported by the interface, the channel and the top level.
package button_conditioner_pkg;

   // Bit position of each button inside btn_raw / press_pulse.
   typedef enum int unsigned {
      BTN_UP    = 0,
      BTN_DOWN  = 1,
      BTN_LEFT  = 2,
      BTN_RIGHT = 3
   } btnIdx_e;

   localparam int unsigned NUM_BUTTONS         = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;  // 10 ms @ 100 MHz
   localparam int unsigned CNT_BITS_DEF        = 20;
   localparam int unsigned LOCKOUT_CYCLES      = 4096;
   localparam int unsigned LOCK_BITS           = $clog2(LOCKOUT_CYCLES + 1);

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the button-side signals of button_conditioner.
//   btn_raw     [3:0] raw asynchronous buttons {R,L,D,U}
//   enable            game enable (PLAY state)
//   press_pulse [3:0] one-cycle press pulses, same bit order as btn_raw
//   press_any         OR of press_pulse
//   press_multi       more than one press_pulse bit set
//   lockout_active    only when BTN_LOCKOUT_EN is defined
//   master: drives buttons/enable (game side); slave: the conditioner.
interface button_conditioner_if;
   import button_conditioner_pkg::*;

   logic [NUM_BUTTONS-1:0] btn_raw;
   logic                   enable;
   logic [NUM_BUTTONS-1:0] press_pulse;
   logic                   press_any;
   logic                   press_multi;
`ifdef BTN_LOCKOUT_EN
   logic                   lockout_active;

   modport master (output btn_raw, enable,
                   input  press_pulse, press_any, press_multi, lockout_active);
   modport slave  (input  btn_raw, enable,
                   output press_pulse, press_any, press_multi, lockout_active);
`else
   modport master (output btn_raw, enable,
                   input  press_pulse, press_any, press_multi);
   modport slave  (input  btn_raw, enable,
                   output press_pulse, press_any, press_multi);
`endif

endinterface

// File: rtl/button_conditioner_btn_debounce_ch.sv
// btn_debounce_ch
//   One button channel: 2-flop synchronizer, counter debounce and a
//   rising-edge detect on the debounced level.
//   clk, reset  system clock, synchronous active-high reset
//   btnRaw      asynchronous raw button level
//   stableRise  high for the one cycle after the debounced level goes 0->1
module btn_debounce_ch #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_BITS        = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btnRaw,
   output logic stableRise
);

   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic                s1;
   logic                s2;
   logic                stableLevel;
   logic                stablePrev;
   logic [CNT_BITS-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         stableLevel <= 1'b0;
         stablePrev  <= 1'b0;
         cnt         <= '0;
      end else begin
         s1         <= btnRaw;
         s2         <= s1;
         stablePrev <= stableLevel;
         // Any return to the stable level restarts the count; the last
         // count value always resolves, so the counter never wraps.
         if (s2 == stableLevel) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stableLevel <= s2;
            cnt         <= '0;
         end else begin
            cnt <= cnt + CNT_BITS'(1);
         end
      end
   end

   assign stableRise = stableLevel & ~stablePrev;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four arrow buttons into one-cycle press pulses for the
//   collision logic. Each button runs through btn_debounce_ch; this level
//   gates with enable and derives press_any / press_multi. All outputs are
//   registered.
//   clk    system clock (100 MHz)
//   reset  synchronous, active-high
//   bus    button_conditioner_if.slave (btn_raw, enable in; press_* out)
//   Optional macro BTN_LOCKOUT_EN: after a press, block all new pulses for
//   LOCKOUT_CYCLES cycles and drive bus.lockout_active while blocking.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_BITS        = CNT_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.slave  bus
);

   logic [NUM_BUTTONS-1:0] rise;
   logic [NUM_BUTTONS-1:0] nextPulse;
   logic [NUM_BUTTONS-1:0] pressPulse;
   logic                   pressAny;
   logic                   pressMulti;
   logic                   pulseAllow;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gCh
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_BITS        (CNT_BITS)
      ) uCh (
         .clk        (clk),
         .reset      (reset),
         .btnRaw     (bus.btn_raw[i]),
         .stableRise (rise[i])
      );
   end

`ifdef BTN_LOCKOUT_EN
   logic [LOCK_BITS-1:0] lockCnt;

   // Loaded on the edge that registers a pulse, so the count covers the
   // press_any cycle and the LOCKOUT_CYCLES-1 cycles after it... plus the
   // final one: a rise registered on any of the next LOCKOUT_CYCLES edges
   // still sees a non-zero count.
   always_ff @(posedge clk) begin
      if (reset) begin
         lockCnt <= '0;
      end else if (nextPulse != '0) begin
         lockCnt <= LOCK_BITS'(LOCKOUT_CYCLES);
      end else if (lockCnt != '0) begin
         lockCnt <= lockCnt - LOCK_BITS'(1);
      end
   end

   always_comb pulseAllow = (lockCnt == '0);
   assign bus.lockout_active = (lockCnt != '0);
`else
   always_comb pulseAllow = 1'b1;
`endif

   always_comb begin
      nextPulse = '0;
      if (bus.enable && pulseAllow) begin
         nextPulse = rise;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pressPulse <= '0;
         pressAny   <= 1'b0;
         pressMulti <= 1'b0;
      end else begin
         pressPulse <= nextPulse;
         pressAny   <= |nextPulse;
         pressMulti <= ($countones(nextPulse) > 1);
      end
   end

   assign bus.press_pulse = pressPulse;
   assign bus.press_any   = pressAny;
   assign bus.press_multi = pressMulti;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed stimulus with DEBOUNCE_CYCLES=4, CNT_BITS=3. A press issued
//   just after edge c is expected to pulse in the cycle after edge c+7.
//   Stimulus pushes expected pulses into a queue; a negedge monitor pops
//   and compares whenever a pulse is presented or one is due.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  pulse;
      logic        multi;
   } exp_t;

   logic clk;
   logic reset;
   int unsigned cyc;
   int unsigned nChecks;
   int unsigned nPass;
   exp_t expQ[$];

   button_conditioner_if bus();

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .CNT_BITS        (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // With the lockout built in, pulses must be spaced past the lockout window.
   task automatic settle(input int unsigned n);
`ifdef BTN_LOCKOUT_EN
      step(n + LOCKOUT_CYCLES);
`else
      step(n);
`endif
   endtask

   task automatic expectPulse(input int unsigned at, input logic [3:0] p, input logic m);
      exp_t e;
      e.cyc = at; e.pulse = p; e.multi = m;
      expQ.push_back(e);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.press_any || bus.press_pulse != 4'b0 ||
             (expQ.size() > 0 && expQ[0].cyc == cyc)) begin
            if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
               chk("spuriousPulse", 32'(bus.press_pulse), 32'(0));
            end else begin
               exp_t e;
               e = expQ.pop_front();
               chk("pulseBits",  32'(bus.press_pulse), 32'(e.pulse));
               chk("pressAny",   32'(bus.press_any),   32'(1));
               chk("pressMulti", 32'(bus.press_multi), 32'(e.multi));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; nChecks = 0; nPass = 0;
      reset = 1'b1;
      bus.btn_raw = 4'b0;
      bus.enable  = 1'b0;
      step(3);
      chk("resetPulse", 32'(bus.press_pulse), 32'(0));
      chk("resetAny",   32'(bus.press_any),   32'(0));
      chk("resetMulti", 32'(bus.press_multi), 32'(0));
      reset = 1'b0;
      bus.enable = 1'b1;
      step(4);

      // Clean U press held for a while
      bus.btn_raw[BTN_UP] = 1'b1;
      expectPulse(cyc + 7, 4'b0001, 1'b0);
      step(20);
      bus.btn_raw[BTN_UP] = 1'b0;
      settle(12);

      // L chatter every cycle never debounces
      for (int i = 0; i < 12; i++) begin
         bus.btn_raw[BTN_LEFT] = (i % 2 == 0);
         step(1);
      end
      bus.btn_raw[BTN_LEFT] = 1'b0;
      step(12);

      // U and R together
      bus.btn_raw[BTN_UP]    = 1'b1;
      bus.btn_raw[BTN_RIGHT] = 1'b1;
      expectPulse(cyc + 7, 4'b1001, 1'b1);
      step(14);
      bus.btn_raw = 4'b0;
      settle(12);

      // R with a one-cycle dropout mid-debounce: count restarts
      bus.btn_raw[BTN_RIGHT] = 1'b1;
      step(3);
      bus.btn_raw[BTN_RIGHT] = 1'b0;
      step(1);
      bus.btn_raw[BTN_RIGHT] = 1'b1;
      expectPulse(cyc + 7, 4'b1000, 1'b0);
      step(14);
      bus.btn_raw[BTN_RIGHT] = 1'b0;
      settle(12);

      // U held: 3-cycle release glitch rejected, 4-cycle release accepted
      bus.btn_raw[BTN_UP] = 1'b1;
      expectPulse(cyc + 7, 4'b0001, 1'b0);
      step(12);
      bus.btn_raw[BTN_UP] = 1'b0;
      step(3);
      bus.btn_raw[BTN_UP] = 1'b1;
      step(12);
`ifdef BTN_LOCKOUT_EN
      step(LOCKOUT_CYCLES);
`endif
      bus.btn_raw[BTN_UP] = 1'b0;
      step(4);
      bus.btn_raw[BTN_UP] = 1'b1;
      expectPulse(cyc + 7, 4'b0001, 1'b0);
      step(12);
      bus.btn_raw[BTN_UP] = 1'b0;
      settle(12);

      // L then D one cycle apart: separate pulses, no multi
      bus.btn_raw[BTN_LEFT] = 1'b1;
      expectPulse(cyc + 7, 4'b0100, 1'b0);
      step(1);
      bus.btn_raw[BTN_DOWN] = 1'b1;
`ifndef BTN_LOCKOUT_EN
      expectPulse(cyc + 7, 4'b0010, 1'b0);
`endif
      step(14);
      bus.btn_raw = 4'b0;
      settle(12);

      // D rises while disabled; enabling while held gives nothing
      bus.enable = 1'b0;
      bus.btn_raw[BTN_DOWN] = 1'b1;
      step(10);
      bus.enable = 1'b1;
      step(10);
      bus.btn_raw[BTN_DOWN] = 1'b0;
      step(12);
      bus.btn_raw[BTN_DOWN] = 1'b1;
      expectPulse(cyc + 7, 4'b0010, 1'b0);
      step(12);
      bus.btn_raw[BTN_DOWN] = 1'b0;
      settle(12);

      // D mid-debounce, 1-cycle reset, D still held: debounce starts over
      begin
         int unsigned c0;
         c0 = cyc;
         bus.btn_raw[BTN_DOWN] = 1'b1;
         step(4);
         reset = 1'b1;
         step(1);
         chk("midResetPulse", 32'(bus.press_pulse), 32'(0));
         reset = 1'b0;
         expectPulse(c0 + 12, 4'b0010, 1'b0);
         step(16);
         bus.btn_raw[BTN_DOWN] = 1'b0;
         settle(12);
      end

`ifdef BTN_LOCKOUT_EN
      // U pulse, R 100 cycles later is dropped, R after the window pulses
      bus.btn_raw[BTN_UP] = 1'b1;
      expectPulse(cyc + 7, 4'b0001, 1'b0);
      step(100);
      bus.btn_raw[BTN_RIGHT] = 1'b1;
      step(20);
      chk("lockoutActive", 32'(bus.lockout_active), 32'(1));
      bus.btn_raw = 4'b0;
      step(LOCKOUT_CYCLES);
      chk("lockoutIdle", 32'(bus.lockout_active), 32'(0));
      bus.btn_raw[BTN_RIGHT] = 1'b1;
      expectPulse(cyc + 7, 4'b1000, 1'b0);
      step(12);
      bus.btn_raw = 4'b0;
      step(12);
`endif

      step(20);
      chk("queueDrained", 32'(expQ.size()), 32'(0));
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
